button_conditioner: RTL and testbench
=====================================

# button_conditioner

Conditions one raw mechanical push-button input for the board-level support logic of the RISC-V processor prototype. It synchronises the asynchronous pin, debounces it with a consecutive-sample counter FSM, and emits a clean level plus single-cycle press, release and auto-repeat pulses. It sits directly upstream of the press counter and display logic: `press_pulse` or `repeat_pulse` drives their increment input, and `level` is the debounced button state.

## Interface
- `SYNC_STAGES`, default 2: synchroniser flip-flop depth, ≥2.
- `DEBOUNCE_CYCLES`, default 16: consecutive identical synchronised samples required to accept a level change, ≥2.
- `HOLD_CYCLES`, default 64: cycles after `press_pulse` until the first `repeat_pulse`.
- `REPEAT_CYCLES`, default 16: spacing between subsequent repeat pulses, 1 ≤ `REPEAT_CYCLES` ≤ `HOLD_CYCLES`.
- `REPEAT_EN`, default 1: 0 disables `repeat_pulse` permanently.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `button_raw`  in  1  raw pin, asynchronous to `clk`, may bounce.
- `level`  out  1  debounced button state, 1 = pressed.
- `press_pulse`  out  1  one-cycle pulse on accepted 0→1.
- `release_pulse`  out  1  one-cycle pulse on accepted 1→0.
- `repeat_pulse`  out  1  one-cycle pulse while held (auto-repeat).
- `busy`  out  1  high while a candidate transition is being qualified.

## Operation
- Synchroniser: a `SYNC_STAGES`-deep flop chain. Its output `s` is the only signal the FSM sees.
- Debounce counter `dcnt` has width clog2(`DEBOUNCE_CYCLES`)+1. Hold counter `hcnt` has width clog2(`HOLD_CYCLES`)+1.
- The FSM has four states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - IDLE: if `s`=1, go to PRESS_WAIT with `dcnt`=1.
  - PRESS_WAIT: if `s`=0, return to IDLE and clear `dcnt` (the glitch is discarded, with no pulse). Else if `dcnt`=`DEBOUNCE_CYCLES`-1, go to PRESSED, set `level`=1, pulse `press_pulse`, and set `hcnt`=0. Otherwise increment `dcnt`.
  - PRESSED: if `s`=0, go to RELEASE_WAIT with `dcnt`=1 and freeze `hcnt`. Otherwise, when `REPEAT_EN`=1, increment `hcnt`. When `hcnt`=`HOLD_CYCLES`-1, pulse `repeat_pulse` and load `hcnt`=`HOLD_CYCLES`-`REPEAT_CYCLES`.
  - RELEASE_WAIT: if `s`=1, return to PRESSED and resume `hcnt` from its frozen value (the bounce is discarded). Else if `dcnt`=`DEBOUNCE_CYCLES`-1, go to IDLE, set `level`=0, pulse `release_pulse`, and clear `hcnt`. Otherwise increment `dcnt`.
- `busy` = (state is PRESS_WAIT or RELEASE_WAIT), registered.
- At most one of `press_pulse`, `release_pulse` and `repeat_pulse` is high in any cycle.
- `repeat_pulse` is never asserted in RELEASE_WAIT, nor in the same cycle as `press_pulse`.

## Timing
- Reset (async assert, sync deassert handled upstream): synchroniser flops = 0, state = IDLE, `dcnt` = `hcnt` = 0. All outputs are 0 while reset is high and in the first cycle after it.
- All outputs are registered, with no combinational path from `button_raw`.
- Press latency: if `button_raw` rises before edge 1 and stays high, `level` and `press_pulse` go high after edge `SYNC_STAGES`+`DEBOUNCE_CYCLES` (default 18). `press_pulse` is high for exactly one cycle.
- Release latency is symmetric: `SYNC_STAGES`+`DEBOUNCE_CYCLES` edges after a clean fall.
- A high or low excursion of `s` lasting fewer than `DEBOUNCE_CYCLES` cycles produces no level change and no pulse.
- Repeat timing, with no bounce: the first `repeat_pulse` comes `HOLD_CYCLES` cycles after `press_pulse`. Subsequent repeat pulses come every `REPEAT_CYCLES` cycles.
- If the button is held through reset deassertion, the block performs a full qualification and then issues `press_pulse`. A press is never implied by reset.
- Reset mid-qualification or mid-hold aborts immediately, with no pulse emitted.

## Test plan
Test parameters for all scenarios: `SYNC_STAGES`=2, `DEBOUNCE_CYCLES`=4, `HOLD_CYCLES`=8, `REPEAT_CYCLES`=3.
- Clean press: `button_raw` 0→1 before edge 1, held → `level`=1 and a single `press_pulse` after edge 6. `busy` is high for 3 cycles before that.
- Bounce: raw toggles 1,0,1,1,0 on alternate cycles, then holds 1 → no pulse during the bounce. Exactly one `press_pulse` follows, 4 cycles after `s` becomes stable high.
- Auto-repeat: hold for 20 cycles after `press_pulse` → `repeat_pulse` at +8, +11, +14, +17 cycles. Never coincident with another pulse.
- Release with mid-release bounce: in PRESSED, drop raw for 2 cycles then restore → no `release_pulse`, and the repeat schedule shifts by the frozen cycles. A clean release then gives `release_pulse` 6 edges after the raw fall, with `level`=0.
- Reset mid-PRESS_WAIT (`dcnt`=2) with raw still held → all outputs 0. After deassert, a full 6-edge qualification, then `press_pulse`.
- `REPEAT_EN`=0: hold for 40 cycles → `repeat_pulse` stays 0, and `level` stays 1.

Source files
------------

// File: rtl/button_conditioner.sv
// Push-button conditioner: synchroniser, debounce FSM, level and
// single-cycle press / release / auto-repeat pulses.
module button_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 64,
    parameter int REPEAT_CYCLES   = 16,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic button_raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic busy
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HW = $clog2(HOLD_CYCLES) + 1;

    localparam logic [DW-1:0] D_ONE    = DW'(1);
    localparam logic [DW-1:0] D_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_ONE    = HW'(1);
    localparam logic [HW-1:0] H_LAST   = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] H_RELOAD = HW'(HOLD_CYCLES - REPEAT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    state_e          state_q, state_d;
    logic [DW-1:0]   dcnt_q, dcnt_d;
    logic [HW-1:0]   hcnt_q, hcnt_d;

    logic level_d, press_d, release_d, repeat_d, busy_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], button_raw};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            dcnt_q        <= '0;
            hcnt_q        <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_d;
            dcnt_q        <= dcnt_d;
            hcnt_q        <= hcnt_d;
            level         <= level_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
            repeat_pulse  <= repeat_d;
            busy          <= busy_d;
        end
    end

    // hcnt is left untouched in RELEASE_WAIT so a bounce resumes the schedule
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        hcnt_d  = hcnt_q;
        unique case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = PRESS_WAIT;
                    dcnt_d  = D_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                    dcnt_d  = '0;
                end else if (dcnt_q == D_LAST) begin
                    state_d = PRESSED;
                    dcnt_d  = '0;
                    hcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q + D_ONE;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d = RELEASE_WAIT;
                    dcnt_d  = D_ONE;
                end else if (REPEAT_EN) begin
                    if (hcnt_q == H_LAST) begin
                        hcnt_d = H_RELOAD;
                    end else begin
                        hcnt_d = hcnt_q + H_ONE;
                    end
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_d = PRESSED;
                    dcnt_d  = '0;
                end else if (dcnt_q == D_LAST) begin
                    state_d = IDLE;
                    dcnt_d  = '0;
                    hcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q + D_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                dcnt_d  = '0;
                hcnt_d  = '0;
            end
        endcase
    end

    always_comb begin
        level_d   = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
        busy_d    = (state_d == PRESS_WAIT) || (state_d == RELEASE_WAIT);
        press_d   = (state_q == PRESS_WAIT) && (state_d == PRESSED);
        release_d = (state_q == RELEASE_WAIT) && (state_d == IDLE);
        repeat_d  = REPEAT_EN && (state_q == PRESSED) && s
                    && (hcnt_q == H_LAST);
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner (DEB=4, HOLD=8, REP=3);
// expected vectors are {level, press, release, repeat, busy}.
module tb_button_conditioner;

    logic clk = 1'b0;
    logic reset;
    logic button_raw;

    logic lvl1, pr1, rl1, rp1, bz1;
    logic lvl2, pr2, rl2, rp2, bz2;
    logic [4:0] o1, o2;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic       raw;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    assign o1 = {lvl1, pr1, rl1, rp1, bz1};
    assign o2 = {lvl2, pr2, rl2, rp2, bz2};

    button_conditioner #(
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES(8),
        .REPEAT_CYCLES(3),
        .REPEAT_EN(1'b1)
    ) dut1 (
        .clk(clk),
        .reset(reset),
        .button_raw(button_raw),
        .level(lvl1),
        .press_pulse(pr1),
        .release_pulse(rl1),
        .repeat_pulse(rp1),
        .busy(bz1)
    );

    button_conditioner #(
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES(8),
        .REPEAT_CYCLES(3),
        .REPEAT_EN(1'b0)
    ) dut2 (
        .clk(clk),
        .reset(reset),
        .button_raw(button_raw),
        .level(lvl2),
        .press_pulse(pr2),
        .release_pulse(rl2),
        .repeat_pulse(rp2),
        .busy(bz2)
    );

    function automatic void add(input logic raw, input logic [4:0] e);
        vec_t v;
        v.raw = raw;
        v.exp = e;
        vecs.push_back(v);
    endfunction

    function automatic logic [4:0] held(input int k);
        logic [4:0] e;
        e[4] = (k >= 6);
        e[3] = (k == 6);
        e[2] = 1'b0;
        e[1] = (k >= 14) && ((k - 14) % 3 == 0);
        e[0] = (k >= 3) && (k <= 5);
        return e;
    endfunction

    task automatic check(input string name, input logic [4:0] act,
                         input logic [4:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic step(input logic raw);
        button_raw = raw;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nrep;
        reset      = 1'b1;
        button_raw = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset dut1", o1, 5'b00000);
        check("reset dut2", o2, 5'b00000);
        reset = 1'b0;

        // clean press and auto-repeat, edges 1..26
        for (int e = 1; e <= 26; e++) add(1'b1, held(e));
        // mid-release bounce, then clean release, edges 27..42
        add(1'b0, 5'b10000); add(1'b0, 5'b10000);
        add(1'b1, 5'b10001); add(1'b1, 5'b10001);
        add(1'b1, 5'b10000); add(1'b1, 5'b10010);
        add(1'b1, 5'b10000); add(1'b1, 5'b10000);
        add(1'b1, 5'b10010); add(1'b0, 5'b10000);
        add(1'b0, 5'b10000); add(1'b0, 5'b10001);
        add(1'b0, 5'b10001); add(1'b0, 5'b10001);
        add(1'b0, 5'b00100); add(1'b0, 5'b00000);
        // press bounce 1,0,1,1,0 then steady, edges 43..61
        add(1'b1, 5'b00000); add(1'b0, 5'b00000);
        add(1'b1, 5'b00001); add(1'b1, 5'b00000);
        add(1'b0, 5'b00001); add(1'b1, 5'b00001);
        add(1'b1, 5'b00000); add(1'b1, 5'b00001);
        add(1'b1, 5'b00001); add(1'b1, 5'b00001);
        add(1'b1, 5'b11000); add(1'b1, 5'b10000);
        add(1'b0, 5'b10000); add(1'b0, 5'b10000);
        add(1'b0, 5'b10001); add(1'b0, 5'b10001);
        add(1'b0, 5'b10001); add(1'b0, 5'b00100);
        add(1'b0, 5'b00000);

        foreach (vecs[i]) begin
            step(vecs[i].raw);
            check($sformatf("vec%0d dut1", i + 1), o1, vecs[i].exp);
            check($sformatf("vec%0d dut2", i + 1), o2,
                  vecs[i].exp & 5'b11101);
        end

        // reset while qualifying a press (dcnt=2), raw held
        step(1'b1);
        step(1'b1);
        step(1'b1);
        check("pw dcnt1", o1, 5'b00001);
        step(1'b1);
        check("pw dcnt2", o1, 5'b00001);
        #2;
        reset = 1'b1;
        #1;
        check("async rst dut1", o1, 5'b00000);
        check("async rst dut2", o2, 5'b00000);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("held rst dut1", o1, 5'b00000);
        reset = 1'b0;

        // requalify after reset, then hold 40 cycles past the press
        nrep = 0;
        for (int k = 1; k <= 46; k++) begin
            step(1'b1);
            check($sformatf("post%0d dut1", k), o1, held(k));
            check($sformatf("post%0d dut2", k), o2, held(k) & 5'b11101);
            if (rp1) nrep++;
        end
        check("repeat count", 5'(nrep), 5'd11);
        check("noreplevel", {4'b0, lvl2}, 5'b00001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
